pwm_duty_decoder: RTL

//  Receive-side counterpart of the square-wave PWM generators: samples a PWM pulse stream,

---
 rtl/pwm_duty_decoder.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: measures the high time of each PWM period in a sampled pulse
// stream, locks its period counter to the stream's rising edges, and recovers the
// slow modulating square wave with threshold hysteresis.
module pwm_duty_decoder #(
   parameter int CNT_W  = 6,
   parameter int LOCK_N = 4,
   parameter int HI_TH  = 48,
   parameter int LO_TH  = 16,
   parameter int RUN_W  = 8
) (
   input  logic             sysclk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             pulse_in,
   output logic [CNT_W:0]   duty_out,
   output logic             duty_valid,
   output logic             locked,
   output logic             level_out,
   output logic             level_chg,
   output logic [RUN_W-1:0] half_len,
   output logic             resync_err
);

   localparam int                LCNT_W   = $clog2(LOCK_N + 1);
   localparam logic [CNT_W-1:0]  PCNT_MAX = '1;
   localparam logic [RUN_W-1:0]  RUN_MAX  = '1;
   localparam logic [CNT_W:0]    HI_LIM   = (CNT_W + 1)'(HI_TH);
   localparam logic [CNT_W:0]    LO_LIM   = (CNT_W + 1)'(LO_TH);
   localparam logic [LCNT_W-1:0] LOCK_LIM = LCNT_W'(LOCK_N);

   typedef enum logic {HUNT, LOCKED} lockState_e;
   typedef enum logic {LVL_LOW, LVL_HIGH} levelState_e;

   logic              syncMeta_q, syncPin_q, pinDly_q;
   logic              rise;
   logic [CNT_W:0]    sExt;
   logic              closeA, closeB, realign, toggle;

   logic [CNT_W-1:0]  pcnt_q, pcnt_d;
   logic [CNT_W:0]    hcnt_q, hcnt_d;
   logic              fresh_q, fresh_d;
   logic [CNT_W:0]    dutyOut_q, dutyOut_d;
   logic              dutyValid_q, dutyValid_d;
   logic              resyncErr_q, resyncErr_d;
   lockState_e        lockState_q, lockState_d;
   logic [LCNT_W-1:0] lockCnt_q, lockCnt_d;
   logic              lockedClose_q, lockedClose_d;
   levelState_e       levelState_q, levelState_d;
   logic              levelChg_q, levelChg_d;
   logic [RUN_W-1:0]  halfLen_q, halfLen_d;
   logic [RUN_W-1:0]  run_q, run_d;

   // Two-flop synchronizer plus one delay stage; left unreset so the pin history survives a clear.
   always_ff @(posedge sysclk) begin
      syncMeta_q <= pulse_in;
      syncPin_q  <= syncMeta_q;
      pinDly_q   <= syncPin_q;
   end

   assign rise = syncPin_q & ~pinDly_q;
   assign sExt = {{CNT_W{1'b0}}, syncPin_q};

   // A misaligned rise in the first period after a clear silently realigns instead of closing,
   // so the first duty_valid after release comes no sooner than one full period.
   assign closeB  = rise && (pcnt_q != '0) && !fresh_q;
   assign realign = rise && (pcnt_q != '0) && fresh_q;
   assign closeA  = !closeB && !realign && (pcnt_q == PCNT_MAX);

   // Next-state logic: period closes, lock tracking, then level hysteresis one cycle after a locked close.
   always_comb begin
      pcnt_d        = pcnt_q + CNT_W'(1);
      hcnt_d        = hcnt_q + sExt;
      fresh_d       = fresh_q;
      dutyOut_d     = dutyOut_q;
      dutyValid_d   = 1'b0;
      resyncErr_d   = 1'b0;
      lockState_d   = lockState_q;
      lockCnt_d     = lockCnt_q;
      lockedClose_d = 1'b0;
      levelState_d  = levelState_q;
      levelChg_d    = 1'b0;
      halfLen_d     = halfLen_q;
      run_d         = run_q;
      toggle        = 1'b0;

      if (rise) begin
         fresh_d = 1'b0;
      end

      if (closeB) begin
         dutyOut_d   = hcnt_q;
         hcnt_d      = (CNT_W + 1)'(1);
         pcnt_d      = CNT_W'(1);
         dutyValid_d = 1'b1;
         resyncErr_d = 1'b1;
         lockState_d = HUNT;
         lockCnt_d   = '0;
         run_d       = '0;
      end else if (realign) begin
         hcnt_d = (CNT_W + 1)'(1);
         pcnt_d = CNT_W'(1);
      end else if (closeA) begin
         dutyOut_d   = hcnt_q + sExt;
         hcnt_d      = '0;
         pcnt_d      = '0;
         dutyValid_d = 1'b1;
         fresh_d     = 1'b0;
         if (lockState_q == LOCKED) begin
            lockedClose_d = 1'b1;
            run_d         = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
         end else if (lockCnt_q == LOCK_LIM - LCNT_W'(1)) begin
            lockState_d = LOCKED;
            lockCnt_d   = '0;
         end else begin
            lockCnt_d = lockCnt_q + LCNT_W'(1);
         end
      end

      if (lockedClose_q) begin
         toggle = ((levelState_q == LVL_LOW)  && (dutyOut_q >= HI_LIM)) ||
                  ((levelState_q == LVL_HIGH) && (dutyOut_q <= LO_LIM));
         if (toggle) begin
            levelState_d = (levelState_q == LVL_LOW) ? LVL_HIGH : LVL_LOW;
            halfLen_d    = run_q;
            run_d        = '0;
            levelChg_d   = 1'b1;
         end
      end
   end

   // State registers; reset and enable=0 both clear everything past the synchronizer.
   always_ff @(posedge sysclk) begin
      if (!rst_n || !enable) begin
         pcnt_q        <= '0;
         hcnt_q        <= '0;
         fresh_q       <= 1'b1;
         dutyOut_q     <= '0;
         dutyValid_q   <= 1'b0;
         resyncErr_q   <= 1'b0;
         lockState_q   <= HUNT;
         lockCnt_q     <= '0;
         lockedClose_q <= 1'b0;
         levelState_q  <= LVL_LOW;
         levelChg_q    <= 1'b0;
         halfLen_q     <= '0;
         run_q         <= '0;
      end else begin
         pcnt_q        <= pcnt_d;
         hcnt_q        <= hcnt_d;
         fresh_q       <= fresh_d;
         dutyOut_q     <= dutyOut_d;
         dutyValid_q   <= dutyValid_d;
         resyncErr_q   <= resyncErr_d;
         lockState_q   <= lockState_d;
         lockCnt_q     <= lockCnt_d;
         lockedClose_q <= lockedClose_d;
         levelState_q  <= levelState_d;
         levelChg_q    <= levelChg_d;
         halfLen_q     <= halfLen_d;
         run_q         <= run_d;
      end
   end

   assign duty_out   = dutyOut_q;
   assign duty_valid = dutyValid_q;
   assign locked     = (lockState_q == LOCKED);
   assign level_out  = (levelState_q == LVL_HIGH);
   assign level_chg  = levelChg_q;
   assign half_len   = halfLen_q;
   assign resync_err = resyncErr_q;

endmodule
